control_ldst: RTL and testbench

Parametrised successor to the lab-7 CPU control FSM. It sequences fetch, decode and execute for the simple RISC datapath and extends the instruction set with LDR, STR, HALT and illegal-opcode trapping. It adds a configurable memory read latency and uses an asynchronous reset. It sits between the instruction register decoder (opcode/op) and the datapath, program counter, address register and memory command port.

---
 rtl/control_ldst.sv | 234 +++++++++++++++++++++++
 tb/tb_control_ldst.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_ldst.sv
// ---------------------------------------------------------------------------
// control_ldst
//   Moore control FSM for the simple RISC datapath: fetch / decode / execute
//   for MOV imm, MOV, MVN, ADD, AND, CMP, LDR, STR, HALT and illegal-opcode
//   trapping. Memory reads are held for MEM_WAIT cycles before data is used.
//
// Parameters
//   MEM_WAIT  cycles mem_cmd=MREAD is held before read data is sampled (1..7)
//   CNT_W     width of the wait counter (must hold MEM_WAIT)
//
// Ports
//   clk, reset            rising-edge clock, async active-high reset
//   opcode, op            instruction fields from the instruction register
//   load_ir, load_addr    instruction / data-address register enables
//   load_pc, reset_pc     program counter enable and reset-value select
//   addr_sel, mem_cmd     memory address mux (1=PC) and command (00/01/10)
//   vsel, write, nsel     register file write mux, enable, one-hot select
//   loada, loadb, loadc   datapath pipeline register enables
//   asel, bsel, loads     ALU input selects and status register enable
//   halt, illegal         stopped (HALT or trap) / stopped on illegal opcode
// ---------------------------------------------------------------------------
module control_ldst #(
    parameter int MEM_WAIT = 1,
    parameter int CNT_W    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       load_ir,
    output logic       load_addr,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       addr_sel,
    output logic [1:0] mem_cmd,
    output logic [1:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       asel,
    output logic       bsel,
    output logic       loadc,
    output logic       loads,
    output logic [2:0] nsel,
    output logic       halt,
    output logic       illegal
);

    typedef enum logic [4:0] {
        S_RESET, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE,
        S_MOV_IM, S_GET_B, S_GET_A, S_ALU, S_ALU_B, S_STATUS, S_WB,
        S_LS_GET_A, S_LS_ADD, S_LS_ADDR, S_MEM_RD, S_LD_WB,
        S_ST_GET_RD, S_ST_PASS, S_MEM_WR, S_HALT, S_ILLEGAL
    } state_t;

    localparam logic [1:0] MC_NONE  = 2'b00;
    localparam logic [1:0] MC_READ  = 2'b01;
    localparam logic [1:0] MC_WRITE = 2'b10;

    localparam logic [4:0] I_MOV_IM = 5'b110_10;
    localparam logic [4:0] I_MOV    = 5'b110_00;
    localparam logic [4:0] I_MVN    = 5'b101_11;
    localparam logic [4:0] I_CMP    = 5'b101_01;

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(MEM_WAIT - 1);

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       ir;
    logic             in_wait, enter_wait;

    assign ir         = {opcode, op};
    assign in_wait    = (state == S_IF1) || (state == S_MEM_RD);
    // Entry into a wait state is a transition from a different state; the
    // wait states themselves only self-loop while counting down.
    assign enter_wait = ((next_state == S_IF1) || (next_state == S_MEM_RD))
                        && (next_state != state);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_RESET;
        else       state <= next_state;
    end

    // Counter is loaded on entry so the state lasts exactly MEM_WAIT cycles;
    // the zero guard keeps it from wrapping when MEM_WAIT=1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      cnt <= '0;
        else if (enter_wait)            cnt <= WAIT_INIT;
        else if (in_wait && cnt != '0)  cnt <= cnt - CNT_W'(1);
    end

    always_comb begin
        next_state = state;
        load_ir    = 1'b0;
        load_addr  = 1'b0;
        load_pc    = 1'b0;
        reset_pc   = 1'b0;
        addr_sel   = 1'b0;
        mem_cmd    = MC_NONE;
        vsel       = 2'b00;
        write      = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        nsel       = 3'b000;
        halt       = 1'b0;
        illegal    = 1'b0;

        case (state)
            S_RESET: begin
                load_pc    = 1'b1;
                reset_pc   = 1'b1;
                next_state = S_IF1;
            end
            S_IF1: begin
                addr_sel = 1'b1;
                mem_cmd  = MC_READ;
                if (cnt == '0) next_state = S_IF2;
            end
            S_IF2: begin
                addr_sel   = 1'b1;
                mem_cmd    = MC_READ;
                load_ir    = 1'b1;
                next_state = S_UPDATE_PC;
            end
            S_UPDATE_PC: begin
                load_pc    = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                // Unknown instruction bits propagate X into the state so a
                // floating IR shows up in simulation rather than as a trap.
                if ($isunknown(ir)) next_state = state_t'('x);
                else begin
                    casez (ir)
                        5'b110_10:          next_state = S_MOV_IM;
                        5'b110_00,
                        5'b101_??:          next_state = S_GET_B;
                        5'b011_00,
                        5'b100_00:          next_state = S_LS_GET_A;
                        5'b111_00:          next_state = S_HALT;
                        default:            next_state = S_ILLEGAL;
                    endcase
                end
            end
            S_MOV_IM: begin
                vsel       = 2'b10;
                write      = 1'b1;
                nsel       = 3'b100;
                next_state = S_IF1;
            end
            S_GET_B: begin
                loadb      = 1'b1;
                nsel       = 3'b001;
                next_state = (ir == I_MOV || ir == I_MVN) ? S_ALU_B : S_GET_A;
            end
            S_GET_A: begin
                loada      = 1'b1;
                nsel       = 3'b100;
                next_state = (ir == I_CMP) ? S_STATUS : S_ALU;
            end
            S_ALU: begin
                loadc      = 1'b1;
                next_state = S_WB;
            end
            S_ALU_B: begin
                asel       = 1'b1;
                loadc      = 1'b1;
                next_state = S_WB;
            end
            S_STATUS: begin
                loads      = 1'b1;
                next_state = S_IF1;
            end
            S_WB: begin
                write      = 1'b1;
                nsel       = 3'b010;
                next_state = S_IF1;
            end
            S_LS_GET_A: begin
                loada      = 1'b1;
                nsel       = 3'b100;
                next_state = S_LS_ADD;
            end
            S_LS_ADD: begin
                bsel       = 1'b1;
                loadc      = 1'b1;
                next_state = S_LS_ADDR;
            end
            S_LS_ADDR: begin
                load_addr  = 1'b1;
                next_state = (opcode == 3'b011) ? S_MEM_RD : S_ST_GET_RD;
            end
            S_MEM_RD: begin
                mem_cmd = MC_READ;
                if (cnt == '0) next_state = S_LD_WB;
            end
            S_LD_WB: begin
                // Read command stays up so mdata is still valid at write-back.
                mem_cmd    = MC_READ;
                vsel       = 2'b01;
                write      = 1'b1;
                nsel       = 3'b010;
                next_state = S_IF1;
            end
            S_ST_GET_RD: begin
                loadb      = 1'b1;
                nsel       = 3'b010;
                next_state = S_ST_PASS;
            end
            S_ST_PASS: begin
                asel       = 1'b1;
                loadc      = 1'b1;
                next_state = S_MEM_WR;
            end
            S_MEM_WR: begin
                mem_cmd    = MC_WRITE;
                next_state = S_IF1;
            end
            S_HALT: begin
                halt = 1'b1;
            end
            S_ILLEGAL: begin
                halt    = 1'b1;
                illegal = 1'b1;
            end
            default: next_state = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_control_ldst.sv
// ---------------------------------------------------------------------------
// tb_control_ldst
//   Bench for control_ldst. Two instances (MEM_WAIT=1 and MEM_WAIT=3) share
//   the clock. Outputs are packed into one struct per instance and checked
//   against per-instruction micro-op traces built from the instruction rules.
// ---------------------------------------------------------------------------
module tb_control_ldst;

    typedef struct packed {
        logic       load_ir, load_addr, load_pc, reset_pc, addr_sel;
        logic [1:0] mem_cmd, vsel;
        logic       write, loada, loadb, asel, bsel, loadc, loads;
        logic [2:0] nsel;
        logic       halt, illegal;
    } outs_t;

    typedef enum {
        M_RST, M_FETCH, M_LIR, M_UPC, M_DEC, M_MOVIM, M_GETB, M_GETA,
        M_ALU, M_ALUB, M_STAT, M_WB, M_LSADD, M_LSADDR, M_RDWAIT, M_LDWB,
        M_STRD, M_MEMWR, M_HALT, M_ILL
    } mop_e;

    typedef struct {
        logic [4:0] code;
        int         next_if1;  // 1-based cycle of next fetch entry, 0 = never
        int         wr, ld, mw, hc, ic;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst  [2];
    logic [4:0] code [2];
    outs_t      outs [2];
    mop_e       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       load_ir, load_addr, load_pc, reset_pc, addr_sel;
        logic [1:0] mem_cmd, vsel;
        logic       write, loada, loadb, asel, bsel, loadc, loads;
        logic [2:0] nsel;
        logic       halt, illegal;

        control_ldst #(.MEM_WAIT(g == 0 ? 1 : 3), .CNT_W(3)) dut (
            .clk(clk), .reset(rst[g]),
            .opcode(code[g][4:2]), .op(code[g][1:0]),
            .load_ir(load_ir), .load_addr(load_addr), .load_pc(load_pc),
            .reset_pc(reset_pc), .addr_sel(addr_sel), .mem_cmd(mem_cmd),
            .vsel(vsel), .write(write), .loada(loada), .loadb(loadb),
            .asel(asel), .bsel(bsel), .loadc(loadc), .loads(loads),
            .nsel(nsel), .halt(halt), .illegal(illegal)
        );

        assign outs[g] = {load_ir, load_addr, load_pc, reset_pc, addr_sel,
                          mem_cmd, vsel, write, loada, loadb, asel, bsel,
                          loadc, loads, nsel, halt, illegal};
    end

    function automatic int wval(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic outs_t out_of(mop_e m);
        outs_t o;
        o = '0;
        case (m)
            M_RST:    begin o.load_pc = 1; o.reset_pc = 1; end
            M_FETCH:  begin o.addr_sel = 1; o.mem_cmd = 2'b01; end
            M_LIR:    begin o.addr_sel = 1; o.mem_cmd = 2'b01; o.load_ir = 1; end
            M_UPC:    o.load_pc = 1;
            M_DEC:    ;
            M_MOVIM:  begin o.vsel = 2'b10; o.write = 1; o.nsel = 3'b100; end
            M_GETB:   begin o.loadb = 1; o.nsel = 3'b001; end
            M_GETA:   begin o.loada = 1; o.nsel = 3'b100; end
            M_ALU:    o.loadc = 1;
            M_ALUB:   begin o.asel = 1; o.loadc = 1; end
            M_STAT:   o.loads = 1;
            M_WB:     begin o.write = 1; o.nsel = 3'b010; end
            M_LSADD:  begin o.bsel = 1; o.loadc = 1; end
            M_LSADDR: o.load_addr = 1;
            M_RDWAIT: o.mem_cmd = 2'b01;
            M_LDWB:   begin o.mem_cmd = 2'b01; o.vsel = 2'b01; o.write = 1; o.nsel = 3'b010; end
            M_STRD:   begin o.loadb = 1; o.nsel = 3'b010; end
            M_MEMWR:  o.mem_cmd = 2'b10;
            M_HALT:   o.halt = 1;
            M_ILL:    begin o.halt = 1; o.illegal = 1; end
            default:  ;
        endcase
        return o;
    endfunction

    function automatic bit is_fetch(outs_t o);
        return o.addr_sel && o.mem_cmd == 2'b01 && !o.load_ir;
    endfunction

    // Expected per-cycle trace of one instruction, starting at fetch.
    task automatic push_instr(input int w, input logic [4:0] c, output bit stop);
        stop = 0;
        for (int i = 0; i < w; i++) exp_q.push_back(M_FETCH);
        exp_q.push_back(M_LIR);
        exp_q.push_back(M_UPC);
        exp_q.push_back(M_DEC);
        if (c == 5'b110_10) exp_q.push_back(M_MOVIM);
        else if (c == 5'b110_00 || c == 5'b101_11) begin
            exp_q.push_back(M_GETB); exp_q.push_back(M_ALUB); exp_q.push_back(M_WB);
        end else if (c == 5'b101_00 || c == 5'b101_10) begin
            exp_q.push_back(M_GETB); exp_q.push_back(M_GETA);
            exp_q.push_back(M_ALU);  exp_q.push_back(M_WB);
        end else if (c == 5'b101_01) begin
            exp_q.push_back(M_GETB); exp_q.push_back(M_GETA); exp_q.push_back(M_STAT);
        end else if (c == 5'b011_00) begin
            exp_q.push_back(M_GETA); exp_q.push_back(M_LSADD); exp_q.push_back(M_LSADDR);
            for (int i = 0; i < w; i++) exp_q.push_back(M_RDWAIT);
            exp_q.push_back(M_LDWB);
        end else if (c == 5'b100_00) begin
            exp_q.push_back(M_GETA); exp_q.push_back(M_LSADD); exp_q.push_back(M_LSADDR);
            exp_q.push_back(M_STRD); exp_q.push_back(M_ALUB); exp_q.push_back(M_MEMWR);
        end else begin
            stop = 1;
            for (int i = 0; i < 20; i++)
                exp_q.push_back(c == 5'b111_00 ? M_HALT : M_ILL);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Leaves the instance in sReset (reset just released, before the edge).
    task automatic do_reset(input int i);
        rst[i] = 1'b1;
        step();
        step();
        rst[i] = 1'b0;
    endtask

    // Runs one instruction from its first fetch cycle, counting activity
    // until the next fetch entry or a 40-cycle budget.
    task automatic measure(input int i, input logic [4:0] c, output int nxt,
                           output int wr, output int ld, output int mw,
                           output int hc, output int ic);
        outs_t o;
        nxt = 0; wr = 0; ld = 0; mw = 0; hc = 0; ic = 0;
        code[i] = c;
        for (int k = 0; k < 40; k++) begin
            o = outs[i];
            wr += int'(o.write);
            ld += int'(o.loads);
            mw += int'(o.mem_cmd == 2'b10);
            hc += int'(o.halt);
            ic += int'(o.illegal);
            step();
            if (is_fetch(outs[i]) && !is_fetch(o)) begin
                nxt = k + 2;
                break;
            end
        end
    endtask

    vec_t tbl[12];

    initial begin
        int nxt, wr, ld, mw, hc, ic, n, bad0;
        bit stop, need_rst, seen;
        logic [4:0] c;
        logic [4:0] legal [8];
        mop_e m;

        tbl[0]  = '{5'b110_10,  6, 1, 0, 0,  0,  0};
        tbl[1]  = '{5'b110_00,  8, 1, 0, 0,  0,  0};
        tbl[2]  = '{5'b101_11,  8, 1, 0, 0,  0,  0};
        tbl[3]  = '{5'b101_00,  9, 1, 0, 0,  0,  0};
        tbl[4]  = '{5'b101_10,  9, 1, 0, 0,  0,  0};
        tbl[5]  = '{5'b101_01,  8, 0, 1, 0,  0,  0};
        tbl[6]  = '{5'b011_00, 10, 1, 0, 0,  0,  0};
        tbl[7]  = '{5'b100_00, 11, 0, 0, 1,  0,  0};
        tbl[8]  = '{5'b111_00,  0, 0, 0, 0, 36,  0};
        tbl[9]  = '{5'b001_00,  0, 0, 0, 0, 36, 36};
        tbl[10] = '{5'b011_01,  0, 0, 0, 0, 36, 36};
        tbl[11] = '{5'b110_01,  0, 0, 0, 0, 36, 36};

        legal = '{5'b110_10, 5'b110_00, 5'b101_11, 5'b101_00,
                  5'b101_10, 5'b101_01, 5'b011_00, 5'b100_00};

        rst[0] = 1'b1; rst[1] = 1'b1;
        code[0] = 5'b000_00; code[1] = 5'b000_00;

        // Reset and fetch sequence, MEM_WAIT=1.
        do_reset(0);
        chk("reset_state", 32'(outs[0]), 32'(out_of(M_RST)));
        step();
        chk("if1_w1", 32'(outs[0]), 32'(out_of(M_FETCH)));
        step();
        chk("if2_w1", 32'(outs[0]), 32'(out_of(M_LIR)));
        step();
        chk("update_pc_w1", 32'(outs[0]), 32'(out_of(M_UPC)));

        // Per-instruction summaries, MEM_WAIT=1.
        foreach (tbl[t]) begin
            do_reset(0);
            step();
            measure(0, tbl[t].code, nxt, wr, ld, mw, hc, ic);
            chk($sformatf("tbl_next_if1_%b", tbl[t].code), nxt, tbl[t].next_if1);
            chk($sformatf("tbl_write_%b", tbl[t].code), wr, tbl[t].wr);
            chk($sformatf("tbl_loads_%b", tbl[t].code), ld, tbl[t].ld);
            chk($sformatf("tbl_memwr_%b", tbl[t].code), mw, tbl[t].mw);
            chk($sformatf("tbl_halt_%b", tbl[t].code), hc, tbl[t].hc);
            chk($sformatf("tbl_illegal_%b", tbl[t].code), ic, tbl[t].ic);
        end

        // MEM_WAIT=3: LDR returns to fetch on cycle 14, STR on cycle 13.
        do_reset(1);
        step();
        measure(1, 5'b011_00, nxt, wr, ld, mw, hc, ic);
        chk("ldr_w3_next_if1", nxt, 14);
        chk("ldr_w3_write", wr, 1);
        measure(1, 5'b100_00, nxt, wr, ld, mw, hc, ic);
        chk("str_w3_next_if1", nxt, 13);
        chk("str_w3_memwr", mw, 1);

        // Asynchronous reset in the middle of the data read wait.
        code[1] = 5'b011_00;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            if (outs[1].load_addr) begin seen = 1; break; end
            step();
        end
        chk("ldr_w3_reach_addr", 32'(seen), 1);
        step();
        chk("memrd_cmd", 32'(outs[1].mem_cmd), 1);
        chk("memrd_addr_sel", 32'(outs[1].addr_sel), 0);
        step();
        rst[1] = 1'b1;
        #1;
        chk("async_reset_mid_read", 32'(outs[1]), 32'(out_of(M_RST)));
        step();
        rst[1] = 1'b0;
        step();
        n = 0;
        while (is_fetch(outs[1]) && n < 10) begin
            n++;
            step();
        end
        chk("if1_len_after_reset_w3", n, 3);

        // Random instruction streams against the trace model.
        for (int i = 0; i < 2; i++) begin
            exp_q.delete();
            do_reset(i);
            exp_q.push_back(M_RST);
            need_rst = 0;
            bad0 = n_bad;
            for (int cy = 0; cy < 2500; cy++) begin
                if (exp_q.size() == 0) begin
                    if (need_rst) begin
                        do_reset(i);
                        exp_q.push_back(M_RST);
                        need_rst = 0;
                    end else begin
                        n = $urandom_range(0, 23);
                        if (n < 16) c = legal[n % 8];
                        else        c = 5'($urandom_range(0, 31));
                        code[i] = c;
                        push_instr(wval(i), c, stop);
                        need_rst = stop;
                    end
                end
                m = exp_q.pop_front();
                chk($sformatf("rand_w%0d_cy%0d_%s_code%b", wval(i), cy, m.name(), code[i]),
                    32'(outs[i]), 32'(out_of(m)));
                if (n_bad != bad0) break;
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
